modulo_matriz_varredura: RTL and testbench

Scan driver that reads the 35-bit LED-matrix register contents (5 columns × 7 rows) and multiplexes them onto the physical 5×7 dot matrix one row at a time. It takes a snapshot of the register at each frame start, so the displayed frame never tears. It inserts a blanking interval at every row change to suppress ghosting. It sits between the matrix register bank and the board's row/column pins.

---
 rtl/modulo_matriz_varredura.sv | 56 +++++
 tb/tb_modulo_matriz_varredura.sv | 119 +++++++++++
 2 files changed

// File: rtl/modulo_matriz_varredura.sv
// modulo_matriz_varredura: 5x7 LED matrix row scanner with frame snapshot and row-change blanking
module modulo_matriz_varredura #(
  parameter int DIV   = 1000,
  parameter int BLANK = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [34:0] m_in,
  output logic [6:0]  lin,
  output logic [4:0]  col,
  output logic        frame_done
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0]   cnt;
  logic [2:0]      row;
  logic [34:0]     snap;
  logic            run;
  logic            dark;
  logic [6:0][4:0] rows;
  assign rows = snap;
  // advance the slot counter and row, snapshot the register at each frame start
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      cnt        <= '0;
      row        <= '0;
      snap       <= '0;
      run        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      run <= en;
      if (!en) begin
        cnt        <= '0;
        row        <= '0;
        frame_done <= 1'b0;
      end else begin
        if (cnt == '0 && row == 3'd0) snap <= m_in;
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAST) row <= (row == 3'd6) ? 3'd0 : row + 3'd1;
        frame_done <= run && row == 3'd6 && cnt == LAST;
      end
    end
  generate
    if (BLANK == 0) begin : g_nb
      assign dark = !run;
    end else begin : g_b
      assign dark = !run || cnt < CW'(BLANK);
    end
  endgenerate
  // rows[6] holds row 0 (top), so row r maps to rows[6-r]
  always_comb begin
    lin = dark ? 7'b0 : 7'b1 << row;
    col = dark ? 5'b11111 : ~rows[3'd6 - row];
  end
endmodule

// File: tb/tb_modulo_matriz_varredura.sv
// tb_modulo_matriz_varredura: directed checks of scan timing, snapshot, blanking and abort
module tb_modulo_matriz_varredura;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        en = 1'b0;
  logic [34:0] m_in = '0;
  logic [6:0]  lin;
  logic [4:0]  col;
  logic        frame_done;
  logic [34:0] snap_m;
  int n_run = 0;
  int n_fail = 0;

  modulo_matriz_varredura #(.DIV(10), .BLANK(2)) dut (
    .clk(clk), .clr(clr), .en(en), .m_in(m_in),
    .lin(lin), .col(col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " lin"}, 32'(lin), 32'h0);
    chk({tag, " col"}, 32'(col), 32'h1f);
    chk({tag, " fd"}, 32'(frame_done), 32'h0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // checks cycles 0..n-1 after enable; cycle c is observed just before edge c
  task automatic scan(input int n, input int chg, input logic [34:0] mnew);
    int s;
    int ph;
    logic [6:0] el;
    logic [4:0] ec;
    for (int c = 0; c < n; c++) begin
      if (c == chg) m_in = mnew;
      if (c % 70 == 0) snap_m = m_in;
      s  = (c / 10) % 7;
      ph = c % 10;
      el = (ph >= 2) ? 7'(1 << s) : 7'h0;
      ec = (ph >= 2) ? ~snap_m[34 - 5 * s -: 5] : 5'h1f;
      chk($sformatf("c%0d lin", c), 32'(lin), 32'(el));
      chk($sformatf("c%0d col", c), 32'(col), 32'(ec));
      chk($sformatf("c%0d fd", c), 32'(frame_done), 32'((c > 0 && c % 70 == 0) ? 1 : 0));
      step();
    end
  endtask

  task automatic restart(input logic [34:0] m);
    clr = 1'b1;
    en = 1'b0;
    step();
    clr = 1'b0;
    m_in = m;
    en = 1'b1;
  endtask

  initial begin
    en = 1'b1;
    m_in = 35'h7FFFFFFFF;
    #1;
    chk_dark("rst0");
    for (int i = 0; i < 5; i++) begin
      step();
      chk_dark($sformatf("rst_hold%0d", i));
    end

    restart(35'h7FFFFFFFF);
    scan(70, -1, '0);

    restart(35'b10101 << 30);
    scan(70, -1, '0);

    restart(35'h2D5A3C96E);
    scan(211, -1, '0);

    restart(35'h555555555);
    scan(140, 35, 35'h0);

    restart(35'h7FFFFFFFF);
    scan(26, -1, '0);
    chk("abort c26 lin", 32'(lin), 32'h4);
    en = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk_dark($sformatf("abort c%0d", 27 + i));
      step();
    end
    en = 1'b1;
    m_in = 35'h1F00000F8;
    scan(43, -1, '0);
    clr = 1'b1;
    #1;
    chk_dark("clr_async");
    #2;
    clr = 1'b0;
    scan(71, -1, '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
